// File: rtl/jtframe_test_inputs_if.sv
// Player-input bundle between the video timing side and the
// scripted input generator.
interface jtframe_test_inputs_if;
   logic       LVBL;
   logic [6:0] game_joystick1;
   logic       button_1p;
   logic       coin_left;

   modport master (
      output LVBL,
      input  game_joystick1,
      input  button_1p,
      input  coin_left
   );

   modport slave (
      input  LVBL,
      output game_joystick1,
      output button_1p,
      output coin_left
   );
endinterface

// File: rtl/jtframe_test_inputs.sv
// Scripted player inputs for TESTINPUTS builds: coin, 1P start,
// then a looping P1 joystick pattern, paced by LVBL frames.
module jtframe_test_inputs #(
   parameter int FRAME_W     = 16,
   parameter int COIN_FRAME  = 60,
   parameter int START_FRAME = 120,
   parameter int PULSE_LEN   = 4,
   parameter int PLAY_FRAME  = 180,
   parameter int HOLD        = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic loop_rst,
   jtframe_test_inputs_if.slave io
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int XW = FRAME_W + 1;

   localparam logic [XW-1:0] COIN_LO  = XW'(COIN_FRAME);
   localparam logic [XW-1:0] COIN_HI  = XW'(COIN_FRAME + PULSE_LEN);
   localparam logic [XW-1:0] START_LO = XW'(START_FRAME);
   localparam logic [XW-1:0] START_HI = XW'(START_FRAME + PULSE_LEN);
   localparam logic [XW-1:0] PLAY_AT  = XW'(PLAY_FRAME);
   localparam logic [HW-1:0] HOLD_M1  = HW'(HOLD - 1);

   logic               r_lvbl_l;
   logic [FRAME_W-1:0] r_frame;
   logic [HW-1:0]      r_hold;
   logic [2:0]         r_step;
   logic [6:0]         r_joy;
   logic               r_start;
   logic               r_coin;

   logic               w_rst;
   logic               w_tick;
   logic [XW-1:0]      w_fx;
   logic               w_play;
   logic               w_coin_on;
   logic               w_start_on;
   logic [6:0]         w_pat;

   assign w_rst      = rst | loop_rst;
   assign w_tick     = r_lvbl_l & ~io.LVBL;
   assign w_fx       = {1'b0, r_frame};
   assign w_play     = w_fx >= PLAY_AT;
   assign w_coin_on  = (w_fx >= COIN_LO) && (w_fx < COIN_HI);
   assign w_start_on = (w_fx >= START_LO) && (w_fx < START_HI);

   always_comb begin
      w_pat = 7'h00;
      unique case (r_step)
         3'd0: w_pat = 7'h00;
         3'd1: w_pat = 7'h08;
         3'd2: w_pat = 7'h01;
         3'd3: w_pat = 7'h04;
         3'd4: w_pat = 7'h02;
         3'd5: w_pat = 7'h10;
         3'd6: w_pat = 7'h18;
         3'd7: w_pat = 7'h20;
      endcase
   end

   // LVBL is tracked even in reset so a low LVBL at release is no edge
   always_ff @(posedge clk) begin
      r_lvbl_l <= io.LVBL;
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_frame <= '0;
         r_hold  <= '0;
         r_step  <= 3'd0;
      end else if (w_tick) begin
         if (r_frame != '1) r_frame <= r_frame + 1'b1;
         if (w_play) begin
            if (r_hold == HOLD_M1) begin
               r_hold <= '0;
               r_step <= r_step + 3'd1;
            end else begin
               r_hold <= r_hold + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_joy   <= 7'h7F;
         r_start <= 1'b1;
         r_coin  <= 1'b1;
      end else begin
         r_joy   <= w_play ? ~w_pat : 7'h7F;
         r_start <= ~w_start_on;
         r_coin  <= ~w_coin_on;
      end
   end

   assign io.game_joystick1 = r_joy;
   assign io.button_1p      = r_start;
   assign io.coin_left      = r_coin;

endmodule

// File: tb/tb_jtframe_test_inputs.sv
// Directed bench for the scripted input generator: walks the
// coin/start windows, joystick playback and both reset paths.
module tb_jtframe_test_inputs;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic loop_rst = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   nf = 0;

   jtframe_test_inputs_if vif ();

   jtframe_test_inputs dut (
      .clk      (clk),
      .rst      (rst),
      .loop_rst (loop_rst),
      .io       (vif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] got,
                      input logic [6:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic frame();
      @(negedge clk) vif.LVBL = 1'b0;
      repeat (2) @(negedge clk);
      vif.LVBL = 1'b1;
      repeat (2) @(negedge clk);
      nf++;
   endtask

   task automatic run_to(input int f);
      while (nf < f) frame();
   endtask

   task automatic outs(input string tag, input logic [6:0] j,
                       input logic b, input logic c);
      chk({tag, "_joy"}, vif.game_joystick1, j);
      chk({tag, "_btn"}, {6'd0, vif.button_1p}, {6'd0, b});
      chk({tag, "_coin"}, {6'd0, vif.coin_left}, {6'd0, c});
   endtask

   task automatic pulse_loop();
      @(negedge clk) loop_rst = 1'b1;
      @(posedge clk) #1;
      @(negedge clk) loop_rst = 1'b0;
      nf = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

   initial begin
      // LVBL already low when reset releases: must not count a frame
      vif.LVBL = 1'b0;
      repeat (3) @(posedge clk);
      #1 outs("reset", 7'h7F, 1'b1, 1'b1);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      vif.LVBL = 1'b1;
      repeat (2) @(negedge clk);

      run_to(59);
      outs("f59", 7'h7F, 1'b1, 1'b1);

      // exact latency of the coin output behind the tick
      @(negedge clk) vif.LVBL = 1'b0;
      @(posedge clk) #1;
      chk("coin_lat0", {6'd0, vif.coin_left}, 7'd1);
      @(posedge clk) #1;
      chk("coin_lat1", {6'd0, vif.coin_left}, 7'd0);
      @(negedge clk) vif.LVBL = 1'b1;
      repeat (2) @(negedge clk);
      nf = 60;

      run_to(61);
      chk("coin61", {6'd0, vif.coin_left}, 7'd0);
      run_to(63);
      chk("coin63", {6'd0, vif.coin_left}, 7'd0);
      run_to(64);
      chk("coin64", {6'd0, vif.coin_left}, 7'd1);

      // long low period must count as a single frame
      @(negedge clk) vif.LVBL = 1'b0;
      repeat (1000) @(negedge clk);
      vif.LVBL = 1'b1;
      repeat (3) @(negedge clk);
      nf = 65;

      run_to(119);
      outs("f119", 7'h7F, 1'b1, 1'b1);
      run_to(120);
      outs("f120", 7'h7F, 1'b0, 1'b1);
      run_to(123);
      outs("f123", 7'h7F, 1'b0, 1'b1);
      run_to(124);
      outs("f124", 7'h7F, 1'b1, 1'b1);

      run_to(179);
      chk("joy179", vif.game_joystick1, 7'h7F);
      run_to(180);
      chk("joy180", vif.game_joystick1, 7'h7F);
      run_to(195);
      chk("joy195", vif.game_joystick1, 7'h7F);
      run_to(196);
      chk("joy196", vif.game_joystick1, 7'h77);
      run_to(211);
      chk("joy211", vif.game_joystick1, 7'h77);
      run_to(212);
      chk("joy212", vif.game_joystick1, 7'h7E);
      run_to(228);
      chk("joy228", vif.game_joystick1, 7'h7B);
      run_to(244);
      chk("joy244", vif.game_joystick1, 7'h7D);
      run_to(260);
      chk("joy260", vif.game_joystick1, 7'h6F);
      run_to(276);
      chk("joy276", vif.game_joystick1, 7'h67);
      run_to(292);
      chk("joy292", vif.game_joystick1, 7'h5F);
      run_to(307);
      chk("joy307", vif.game_joystick1, 7'h5F);
      run_to(308);
      outs("f308", 7'h7F, 1'b1, 1'b1);
      run_to(324);
      chk("joy324", vif.game_joystick1, 7'h77);

      pulse_loop();
      outs("loop1", 7'h7F, 1'b1, 1'b1);

      run_to(59);
      chk("rep59", {6'd0, vif.coin_left}, 7'd1);
      run_to(61);
      chk("rep61", {6'd0, vif.coin_left}, 7'd0);

      pulse_loop();
      outs("loop2", 7'h7F, 1'b1, 1'b1);

      run_to(200);
      chk("rep200", vif.game_joystick1, 7'h77);
      pulse_loop();
      outs("loop3", 7'h7F, 1'b1, 1'b1);
      run_to(60);
      chk("rep2_60", {6'd0, vif.coin_left}, 7'd0);
      chk("rep2_joy", vif.game_joystick1, 7'h7F);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
